// File: rtl/tdm_demux.sv
// tdm_demux: receive end of a time-division multiplexed lane.
//
// Follows slot position from a frame-sync marker. Slots 0..SLOTS-2 are collected
// in a shadow register. The last slot goes straight into the parallel output
// together with the shadow contents, so the consumer only ever sees complete
// frames (double buffered).
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous reset, active low
//   en           sample enable; din/fsync are meaningful only when en=1
//   din          current slot word
//   fsync        marks din as slot 0 of a frame (qualified by en)
//   dout         last complete frame; slot k at dout[k*WIDTH +: WIDTH]
//   frame_valid  1-cycle pulse: dout just updated
//   sync_err     1-cycle pulse: framing error detected
//   locked       1 while the FSM is in LOCKED (this is the FSM state view)
//   cur_slot     slot index the next enabled sample will fill
//
// Handshake: there is no backpressure. Each enabled edge consumes one slot word.
// frame_valid is a single-cycle strobe, and dout stays stable until the next strobe
// or until reset.
module tdm_demux #(
    parameter int WIDTH = 8,
    parameter int SLOTS = 4,
    localparam int CW = $clog2(SLOTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [WIDTH-1:0]       din,
    input  logic                   fsync,
    output logic [SLOTS*WIDTH-1:0] dout,
    output logic                   frame_valid,
    output logic                   sync_err,
    output logic                   locked,
    output logic [CW-1:0]          cur_slot
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_SLOT = CW'(SLOTS - 1);

    state_t                      state;
    logic [CW-1:0]               cnt;
    // Slots 0..SLOTS-2 only. The last slot is written directly into dout.
    logic [(SLOTS-1)*WIDTH-1:0]  shadow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= HUNT;
            cnt         <= '0;
            shadow      <= '0;
            dout        <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            // Both strobes default low, so each pulse lasts exactly one cycle.
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (en) begin
                case (state)
                    HUNT: begin
                        if (fsync) begin
                            shadow[0 +: WIDTH] <= din;
                            cnt                <= CW'(1);
                            state              <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (cnt == '0) begin
                            if (fsync) begin
                                shadow[0 +: WIDTH] <= din;
                                cnt                <= CW'(1);
                            end else begin
                                // Missing sync: lose lock and hunt again.
                                sync_err <= 1'b1;
                                cnt      <= '0;
                                state    <= HUNT;
                            end
                        end else if (fsync) begin
                            // Early sync: drop the partial frame and restart at slot 0.
                            sync_err           <= 1'b1;
                            shadow[0 +: WIDTH] <= din;
                            cnt                <= CW'(1);
                        end else if (cnt == LAST_SLOT) begin
                            dout        <= {din, shadow};
                            frame_valid <= 1'b1;
                            cnt         <= '0;
                        end else begin
                            for (int k = 1; k < SLOTS - 1; k++) begin
                                if (cnt == CW'(k)) begin
                                    shadow[k*WIDTH +: WIDTH] <= din;
                                end
                            end
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= HUNT;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign locked   = (state == LOCKED);
    assign cur_slot = cnt;

endmodule
